// File: rtl/add_seq_64_pkg.sv
// rtl/add_seq_64_pkg.sv - shared types and constants for the sequential chunked adder
package add_seq_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_CHUNK = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counters need at least one bit even when only one step exists.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_seq_64_if.sv
// rtl/add_seq_64_if.sv - operand/result handshake bundle for add_seq_64
interface add_seq_64_if
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

endinterface

// File: rtl/add_seq_64_chunk_cla.sv
// rtl/add_seq_64_chunk_cla.sv - combinational CHUNK-bit carry look-ahead slice
module chunk_cla
    import add_seq_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK:0]   w_c;
    logic             w_term;
    logic             w_prop;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is the flat OR of generate terms gated by the propagate chain below them.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_prop = 1'b0;
        w_c[0] = i_cin;
        for (int i = 0; i < CHUNK; i++) begin
            w_term = w_g[i];
            w_prop = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_prop & w_g[j]);
                w_prop = w_prop & w_p[j];
            end
            w_c[i+1] = w_term | (w_prop & i_cin);
        end
    end

    assign o_sum  = w_p ^ w_c[CHUNK-1:0];
    assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/add_seq_64.sv
// rtl/add_seq_64.sv - WIDTH-bit adder computed one CHUNK slice per cycle, LSB first
module add_seq_64
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    add_seq_64_if.slave  bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = clog2_min1(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("add_seq_64: WIDTH must be a multiple of CHUNK");
    end

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;

    logic [CHUNK-1:0]   w_a_slice;
    logic [CHUNK-1:0]   w_b_slice;
    logic [CHUNK-1:0]   w_slice_sum;
    logic               w_slice_cout;

    assign w_a_slice = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_slice = r_b[r_idx*CHUNK +: CHUNK];

    chunk_cla #(
        .CHUNK (CHUNK)
    ) u_cla (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.in_a;
                        r_b        <= bus.in_b;
                        r_carry    <= bus.in_cin;
                        r_idx      <= '0;
                        r_sum      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx*CHUNK +: CHUNK] <= w_slice_sum;
                    r_carry                     <= w_slice_cout;
                    if (r_idx == LAST) begin
                        // The top slice result carries the final sum MSB.
                        r_idx       <= '0;
                        r_cout      <= w_slice_cout;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_slice_sum[CHUNK-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_add_seq_64.sv
// tb/tb_add_seq_64.sv - self-checking bench for add_seq_64 at CHUNK 2, 4 and 8
module tb_add_seq_64;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_cin;
    logic        out_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;

    int checks;
    int errors;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];
    int   lat_n [3] = '{32, 16, 8};

    add_seq_64_if #(.WIDTH(64)) if2 ();
    add_seq_64_if #(.WIDTH(64)) if4 ();
    add_seq_64_if #(.WIDTH(64)) if8 ();

    assign if2.in_valid = in_valid;  assign if4.in_valid = in_valid;  assign if8.in_valid = in_valid;
    assign if2.in_a = in_a;          assign if4.in_a = in_a;          assign if8.in_a = in_a;
    assign if2.in_b = in_b;          assign if4.in_b = in_b;          assign if8.in_b = in_b;
    assign if2.in_cin = in_cin;      assign if4.in_cin = in_cin;      assign if8.in_cin = in_cin;
    assign if2.out_ready = out_ready; assign if4.out_ready = out_ready; assign if8.out_ready = out_ready;

    logic [2:0]  ov, ir, oc, oo, bz;
    logic [63:0] os [3];
    assign ov = {if8.out_valid, if4.out_valid, if2.out_valid};
    assign ir = {if8.in_ready,  if4.in_ready,  if2.in_ready};
    assign oc = {if8.out_cout,  if4.out_cout,  if2.out_cout};
    assign oo = {if8.out_ovf,   if4.out_ovf,   if2.out_ovf};
    assign bz = {if8.busy,      if4.busy,      if2.busy};
    assign os[0] = if2.out_sum;
    assign os[1] = if4.out_sum;
    assign os[2] = if8.out_sum;

    add_seq_64 #(.WIDTH(64), .CHUNK(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    add_seq_64 #(.WIDTH(64), .CHUNK(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    add_seq_64 #(.WIDTH(64), .CHUNK(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t model(input logic [63:0] a, input logic [63:0] b, input logic cin);
        vec_t        v;
        logic [64:0] full;
        full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.sum  = full[63:0];
        v.cout = full[64];
        v.ovf  = (a[63] == b[63]) && (full[63] != a[63]);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        check("in_ready_before_issue", {63'd0, ir[0]}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input vec_t v);
        int          lat [3];
        logic [63:0] s [3];
        logic        c [3];
        logic        o [3];
        for (int d = 0; d < 3; d++) begin
            lat[d] = 0; s[d] = '0; c[d] = 1'b0; o[d] = 1'b0;
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && ov[d]) begin
                    lat[d] = k; s[d] = os[d]; c[d] = oc[d]; o[d] = oo[d];
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_lat_n%0d", tag, lat_n[d]), 64'(lat[d]), 64'(lat_n[d]));
            check($sformatf("%s_sum_n%0d", tag, lat_n[d]), s[d], v.sum);
            check($sformatf("%s_cout_n%0d", tag, lat_n[d]), {63'd0, c[d]}, {63'd0, v.cout});
            check($sformatf("%s_ovf_n%0d", tag, lat_n[d]), {63'd0, o[d]}, {63'd0, v.ovf});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_valid_%0d", tag, d), {63'd0, ov[d]}, 64'd0);
            check($sformatf("%s_busy_%0d", tag, d), {63'd0, bz[d]}, 64'd0);
            check($sformatf("%s_sum_%0d", tag, d), os[d], 64'd0);
            check($sformatf("%s_cout_ovf_%0d", tag, d), {62'd0, oc[d], oo[d]}, 64'd0);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cin    = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        vecs[0] = '{64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{64'd0, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0};
        for (int i = 6; i < 12; i++) begin
            vecs[i] = model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1, 0)));
        end

        repeat (3) tick();
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        tick();
        check("in_ready_after_reset", {61'd0, ir}, 64'd7);

        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_idle");
        check("in_ready_idle_reset", {61'd0, ir}, 64'd7);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin);
            collect($sformatf("vec%0d", i), vecs[i]);
        end

        // Result held in DONE while new operands wait at the input.
        out_ready = 1'b0;
        issue(64'd100, 64'd23, 1'b0);
        begin
            int seen;
            seen = 0;
            for (int k = 1; k <= 40 && seen == 0; k++) begin
                tick();
                if (ov[0]) seen = k;
            end
            check("hold_latency", 64'(seen), 64'd32);
        end
        in_a     = 64'd3;
        in_b     = 64'd5;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_valid_%0d", i), {63'd0, ov[0]}, 64'd1);
            check($sformatf("hold_sum_%0d", i), os[0], 64'd123);
            check($sformatf("hold_ready_%0d", i), {63'd0, ir[0]}, 64'd0);
            check($sformatf("hold_busy_%0d", i), {63'd0, bz[0]}, 64'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("release_valid", {63'd0, ov[0]}, 64'd0);
        check("release_ready", {63'd0, ir[0]}, 64'd1);
        tick();
        in_valid = 1'b0;
        collect("back_to_back", model(64'd3, 64'd5, 1'b0));

        // Reset in the middle of RUN, with a non-zero partial sum already written.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        repeat (10) tick();
        check("partial_sum_nonzero", {63'd0, (os[0] != 64'd0)}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_run");
        check("in_ready_run_reset", {61'd0, ir}, 64'd7);
        tick();
        rst_n = 1'b1;
        tick();
        issue(64'd10, 64'd20, 1'b0);
        collect("after_reset", model(64'd10, 64'd20, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
